i3c_bus_io_ctrl: RTL
====================

Name: i3c_bus_io_ctrl

Overview:
- Parametrised bus-side pad controller between the I3C core and the SCL/SDA pads.
- Supports multiple SDA lanes for HDR multi-lane operation, and a controller mode in which it drives SCL.
- Output path: registered drive data; open-drain/push-pull (OD/PP) selected per lane.
- Input path: synchroniser, optional spike filter, SCL edge pulses.
- Monitoring: per-lane arbitration-loss detection (OD) and sticky contention detection (PP).

Parameters:
- NumSdaLanes, 1, number of SDA lanes (>=1).
- SyncStages, 2, input synchroniser depth (>=2).
- FilterCycles, 3, consecutive stable cycles needed before a filtered input changes (>=1).
- ContentionDelay, 4, cycles a PP drive value must be held before its pad readback is checked (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- ctrl_mode_i  in  1  1 = controller (may drive SCL), 0 = target
- filter_en_i  in  1  enable spike filter on all inputs
- arb_en_i  in  1  enable arbitration-loss detection
- err_clr_i  in  1  clear all contention flags
- scl_drv_i  in  1  SCL drive value from core
- scl_pp_i  in  1  SCL push-pull select
- sda_drv_i  in  NumSdaLanes  SDA drive values from core
- sel_od_pp_i  in  NumSdaLanes  per-lane 1 = PP, 0 = OD
- scl_i  in  1  raw SCL pad input
- sda_i  in  NumSdaLanes  raw SDA pad inputs
- scl_o / scl_oe_o  out  1  SCL pad output / output enable
- sda_o / sda_oe_o  out  NumSdaLanes  SDA pad outputs / output enables
- scl_filt_o  out  1  filtered SCL
- sda_filt_o  out  NumSdaLanes  filtered SDA
- scl_rise_o / scl_fall_o  out  1  single-cycle filtered SCL edge pulses
- arb_lost_o  out  NumSdaLanes  single-cycle arbitration-loss pulse
- contention_o  out  NumSdaLanes  sticky PP contention flag

Behaviour:
- Reset (rst_i high at an edge) forces:
  - scl_o=1, scl_oe_o=0; sda_o=all 1, sda_oe_o=0.
  - Synchroniser stages, filt_o and all filter state = 1 (bus idle).
  - Filter and contention counters = 0.
  - scl_rise_o=scl_fall_o=0, arb_lost_o=0, contention_o=0.
  - Reset mid-transfer releases the bus on the next edge.
- Output path:
  - scl_drv_i, scl_pp_i, sda_drv_i and sel_od_pp_i are registered (_q); 1-cycle latency to the pads.
  - sda_o[k] = sda_drv_q[k]; sda_oe_o[k] = sel_q[k] | ~sda_drv_q[k]. OD drive 1 therefore means hi-z; PP drives both levels.
  - scl_o = scl_drv_q; scl_oe_o = ctrl_mode_q & (scl_pp_q | ~scl_drv_q); ctrl_mode_i is also registered.
  - In target mode scl_oe_o=0 unconditionally.
- Synchroniser: SyncStages flops per input; sync value valid SyncStages edges after a pad change.
- Filter, per signal, with saturating counter cnt of width $clog2(FilterCycles+1):
  - filter_en_i=0: filt <= sync every edge; cnt=0.
  - filter_en_i=1, sync==filt: cnt<=0.
  - filter_en_i=1, sync!=filt and cnt==FilterCycles-1: filt<=sync, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Pad-to-filt latency is SyncStages+FilterCycles edges when enabled, SyncStages+1 when disabled.
  - A glitch shorter than FilterCycles synced cycles never reaches filt.
  - FilterCycles=1 is equivalent to disabled.
- Edge pulses, combinational from scl_filt and its 1-cycle delayed copy:
  - scl_rise_o = filt & ~filt_d; scl_fall_o = ~filt & filt_d.
  - Each is asserted in the first cycle filt shows the new value.
- Arbitration loss: arb_lost_o[k] = arb_en_i & scl_rise_o & ~sel_q[k] & sda_drv_q[k] & ~sda_filt_o[k]. It is a pulse only and holds no state.
- Contention, per lane, with counter ccnt of width $clog2(ContentionDelay+1):
  - ccnt <= 0 whenever sel_q[k]=0 or sda_drv_q / sel_q changed this cycle.
  - Otherwise ccnt increments, saturating at ContentionDelay.
  - When ccnt==ContentionDelay and sda_filt_o[k]!=sda_drv_q[k], contention_o[k] <= 1.
  - err_clr_i clears all flags. If set and clear occur in the same cycle, set wins.

Test Plan:
- Reset values, filter_en_i=1, SyncStages=2, FilterCycles=3: assert rst_i 2 cycles → scl_o=1, scl_oe_o=0, sda_oe_o=0, filt=1, contention_o=0.
- OD/PP table, lane 0: (sel,drv)=(0,0) → oe=1, o=0; (0,1) → oe=0; (1,0) → oe=1, o=0; (1,1) → oe=1, o=1; each appears 1 cycle after the input change.
- Spike filter on sda_i[0]: low pulses of 2 clk → filt stays 1; low pulse of 4 clk → filt falls exactly 5 edges after the pad edge. With filter_en_i=0 it falls after 3 edges.
- SCL edges / controller mode: ctrl_mode_i=1, scl_pp_i=0, scl_drv toggling → scl_oe_o=~scl_drv_q. Loop scl_o back to scl_i → one scl_rise_o and one scl_fall_o pulse per period. ctrl_mode_i=0 → scl_oe_o=0.
- Arbitration: arb_en_i=1, lane 0 OD, drv=1, pad held 0 → arb_lost_o[0] pulses in the scl_rise_o cycle. With arb_en_i=0, or drv=0 → no pulse.
- Contention, ContentionDelay=4, NumSdaLanes=2: lane 1 PP drv=1, pad tied 0 → contention_o[1]=1 after the delay, contention_o[0] stays 0. err_clr_i in the same cycle as a new detection → flag stays 1. Pulse err_clr_i after the pad is released → flag 0.

Source files
------------

// File: rtl/i3c_bus_io_ctrl.sv
// I3C bus-side pad controller: registered SCL/SDA drive with per-lane OD/PP,
// synchronised and spike-filtered inputs, SCL edges, arbitration and contention.
module i3c_bus_io_ctrl #(
  parameter int NumSdaLanes     = 1,
  parameter int SyncStages      = 2,
  parameter int FilterCycles    = 3,
  parameter int ContentionDelay = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ctrl_mode_i,
  input  logic                   filter_en_i,
  input  logic                   arb_en_i,
  input  logic                   err_clr_i,
  input  logic                   scl_drv_i,
  input  logic                   scl_pp_i,
  input  logic [NumSdaLanes-1:0] sda_drv_i,
  input  logic [NumSdaLanes-1:0] sel_od_pp_i,
  input  logic                   scl_i,
  input  logic [NumSdaLanes-1:0] sda_i,
  output logic                   scl_o,
  output logic                   scl_oe_o,
  output logic [NumSdaLanes-1:0] sda_o,
  output logic [NumSdaLanes-1:0] sda_oe_o,
  output logic                   scl_filt_o,
  output logic [NumSdaLanes-1:0] sda_filt_o,
  output logic                   scl_rise_o,
  output logic                   scl_fall_o,
  output logic [NumSdaLanes-1:0] arb_lost_o,
  output logic [NumSdaLanes-1:0] contention_o
);

  localparam int NumSig = NumSdaLanes + 1;
  localparam int FcW    = $clog2(FilterCycles + 1);
  localparam int CdW    = $clog2(ContentionDelay + 1);
  localparam logic [FcW-1:0] FcLast = FcW'(FilterCycles - 1);
  localparam logic [CdW-1:0] CdMax  = CdW'(ContentionDelay);

  logic                   ctrl_mode_q, ctrl_mode_d;
  logic                   scl_drv_q, scl_drv_d;
  logic                   scl_pp_q, scl_pp_d;
  logic [NumSdaLanes-1:0] sda_drv_q, sda_drv_d;
  logic [NumSdaLanes-1:0] sel_q, sel_d;

  logic [NumSig-1:0][SyncStages-1:0] sync_q, sync_d;
  logic [NumSig-1:0]                 filt_q, filt_d;
  logic [NumSig-1:0][FcW-1:0]        cnt_q, cnt_d;
  logic                              scl_dly_q, scl_dly_d;

  logic [NumSdaLanes-1:0][CdW-1:0] ccnt_q, ccnt_d;
  logic [NumSdaLanes-1:0]          cont_q, cont_d;

  logic [NumSig-1:0] raw;
  logic [NumSig-1:0] sync_val;

  assign raw = {sda_i, scl_i};

  always_comb begin
    ctrl_mode_d = ctrl_mode_i;
    scl_drv_d   = scl_drv_i;
    scl_pp_d    = scl_pp_i;
    sda_drv_d   = sda_drv_i;
    sel_d       = sel_od_pp_i;
  end

  // Index 0 is SCL, indices 1..NumSdaLanes are the SDA lanes.
  always_comb begin
    sync_d    = sync_q;
    filt_d    = filt_q;
    cnt_d     = cnt_q;
    sync_val  = '0;
    scl_dly_d = filt_q[0];
    for (int i = 0; i < NumSig; i++) begin
      sync_d[i]   = {sync_q[i][SyncStages-2:0], raw[i]};
      sync_val[i] = sync_q[i][SyncStages-1];
      if (!filter_en_i) begin
        filt_d[i] = sync_val[i];
        cnt_d[i]  = '0;
      end else if (sync_val[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == FcLast) begin
        filt_d[i] = sync_val[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // A PP lane is only judged after its drive value has settled on the pad.
  always_comb begin
    ccnt_d = ccnt_q;
    cont_d = cont_q;
    for (int k = 0; k < NumSdaLanes; k++) begin
      if (!sel_q[k] || (sda_drv_d[k] != sda_drv_q[k]) ||
          (sel_d[k] != sel_q[k])) begin
        ccnt_d[k] = '0;
      end else if (ccnt_q[k] != CdMax) begin
        ccnt_d[k] = ccnt_q[k] + 1'b1;
      end
      if (err_clr_i) begin
        cont_d[k] = 1'b0;
      end
      if ((ccnt_q[k] == CdMax) &&
          (sda_filt_o[k] != sda_drv_q[k])) begin
        cont_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_mode_q <= 1'b0;
      scl_drv_q   <= 1'b1;
      scl_pp_q    <= 1'b0;
      sda_drv_q   <= '1;
      sel_q       <= '0;
      sync_q      <= '1;
      filt_q      <= '1;
      cnt_q       <= '0;
      scl_dly_q   <= 1'b1;
      ccnt_q      <= '0;
      cont_q      <= '0;
    end else begin
      ctrl_mode_q <= ctrl_mode_d;
      scl_drv_q   <= scl_drv_d;
      scl_pp_q    <= scl_pp_d;
      sda_drv_q   <= sda_drv_d;
      sel_q       <= sel_d;
      sync_q      <= sync_d;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      scl_dly_q   <= scl_dly_d;
      ccnt_q      <= ccnt_d;
      cont_q      <= cont_d;
    end
  end

  assign scl_o        = scl_drv_q;
  assign scl_oe_o     = ctrl_mode_q & (scl_pp_q | ~scl_drv_q);
  assign sda_o        = sda_drv_q;
  assign sda_oe_o     = sel_q | ~sda_drv_q;
  assign scl_filt_o   = filt_q[0];
  assign sda_filt_o   = filt_q[NumSig-1:1];
  assign scl_rise_o   = filt_q[0] & ~scl_dly_q;
  assign scl_fall_o   = ~filt_q[0] & scl_dly_q;
  assign arb_lost_o   = {NumSdaLanes{arb_en_i & scl_rise_o}} &
                        ~sel_q & sda_drv_q & ~sda_filt_o;
  assign contention_o = cont_q;

endmodule
